decoder_arbiter: RTL and testbench

Shares one instance of the 7-bit-input decoder between several requesters. Each requester presents a 7-bit code with a valid/ready handshake. The arbiter grants one requester at a time, drives the winning code onto the decoder input, holds it for a fixed settle time, samples the decoder output and returns it to the winner as a one-cycle response. It sits between the project's input sources and the decoder, replacing the direct `io_in` hookup.

---
 rtl/decoder_arb_pkg.sv | 14 +
 rtl/decoder_arb_pick.sv | 51 +++++
 rtl/decoder_arbiter.sv | 93 +++++++++
 tb/tb_decoder_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared types and constants for the decoder arbiter.
package decoder_arb_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  localparam int DEF_CODE_W = 7;
  localparam int DEF_RES_W  = 8;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_arb_pick.sv
// Combinational winner select: round-robin from last grant, or fixed
// priority (lowest index) when DECODER_ARB_FIXED_PRIO_EN is defined.
module decoder_arb_pick
  import decoder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
`ifndef DECODER_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]   last,
`endif
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

`ifdef DECODER_ARB_FIXED_PRIO_EN
  always_comb begin
    idx = '0;
    // Descending scan so the lowest asserted index is the final assignment.
    for (int i = NREQ - 1; i >= 0; i--)
      if (valid[i]) idx = IW'(i);
  end
`else
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    // Search starts one past the last grant and wraps.
    for (int k = 1; k <= NREQ; k++) begin
      pos = IW'((int'(last) + k) % NREQ);
      if (!found && valid[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end
`endif

  assign any = |valid;

  always_comb begin
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Time-shares one decoder among NREQ requesters: grant, hold code for SETTLE
// cycles, sample, return a one-cycle response. Option: DECODER_ARB_FIXED_PRIO_EN.
module decoder_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int CODE_W = DEF_CODE_W,
  parameter int RES_W  = DEF_RES_W,
  parameter int SETTLE = 2,
  parameter int IW     = idx_w(NREQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [RES_W-1:0]         rsp_result,
  output logic [CODE_W-1:0]        dec_code,
  input  logic [RES_W-1:0]         dec_result,
  output logic [IW-1:0]            grant_id,
  output logic                     busy
);

  localparam int CW = idx_w(SETTLE);

  if (SETTLE < 1) begin : g_bad_settle
    $error("decoder_arbiter: SETTLE must be >= 1");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

`ifndef DECODER_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   last_q;
`endif

  decoder_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid  (req_valid),
`ifndef DECODER_ARB_FIXED_PRIO_EN
    .last   (last_q),
`endif
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign req_ready = (state == IDLE) ? pick_oh : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant_id] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dec_code   <= '0;
      rsp_result <= '0;
      grant_id   <= '0;
`ifndef DECODER_ARB_FIXED_PRIO_EN
      last_q     <= IW'(NREQ - 1);
`endif
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          dec_code <= req_code[int'(pick_idx) * CODE_W +: CODE_W];
          grant_id <= pick_idx;
`ifndef DECODER_ARB_FIXED_PRIO_EN
          last_q   <= pick_idx;
`endif
          cnt      <= CW'(SETTLE - 1);
          state    <= HOLD;
        end
        // Sample on the edge closing the last settle cycle.
        HOLD: if (cnt == '0) begin
          rsp_result <= dec_result;
          state      <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench with a response scoreboard for decoder_arbiter.
module tb_decoder_arbiter;

  localparam int NREQ = 4, CW = 7, RW = 8, SETTLE = 2;

  logic clock = 1'b0, reset_n = 1'b0;

  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [NREQ*CW-1:0] req_code;
  logic [RW-1:0]      rsp_result, dec_result;
  logic [CW-1:0]      dec_code;
  logic [1:0]         grant_id;
  logic               busy;

  logic [NREQ-1:0]    req_valid3, req_ready3, rsp_valid3;
  logic [NREQ*CW-1:0] req_code3;
  logic [RW-1:0]      rsp_result3, dec_result3;
  logic [CW-1:0]      dec_code3;
  logic [1:0]         grant_id3;
  logic               busy3;

  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  function automatic logic [RW-1:0] dec_model(input logic [CW-1:0] c);
    return {c, ^c} ^ 8'h3C;
  endfunction

  assign dec_result = dec_model(dec_code);

  decoder_arbiter #(.NREQ(NREQ), .CODE_W(CW), .RES_W(RW), .SETTLE(SETTLE)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .dec_code(dec_code), .dec_result(dec_result), .grant_id(grant_id), .busy(busy)
  );

  decoder_arbiter #(.NREQ(NREQ), .CODE_W(CW), .RES_W(RW), .SETTLE(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid3), .req_code(req_code3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_result(rsp_result3),
    .dec_code(dec_code3), .dec_result(dec_result3), .grant_id(grant_id3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic int exp_win(input logic [NREQ-1:0] v, input int p);
`ifdef DECODER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Scoreboard: push on acceptance, pop on response.
  typedef struct { int id; logic [RW-1:0] res; int due; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   mptr = NREQ - 1, mcyc = 0, w;

  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      mptr = NREQ - 1;
    end else begin
      mcyc++;
      if (req_valid != 0 && req_ready != 0) begin
        w = exp_win(req_valid, mptr);
        chk("sb_winner", 32'(req_ready), 32'(1 << w));
        sb.push_back('{id: w, res: dec_model(req_code[w*CW +: CW]), due: mcyc + SETTLE + 1});
        mptr = w;
      end
      if (rsp_valid != 0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_valid), 32'(1 << e.id));
          chk("rsp_data", 32'(rsp_result), 32'(e.res));
          chk("rsp_time", mcyc, e.due);
        end
      end else if (sb.size() != 0 && mcyc >= sb[0].due) begin
        e = sb.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

`ifdef DECODER_ARB_FIXED_PRIO_EN
  int exp_order[5] = '{0, 0, 0, 0, 0};
`else
  int exp_order[5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    int n, gid_exp;
    int ids[5], acc_cyc[5];
    logic gid_pend;

    req_valid = '0; req_code = '0;
    req_valid3 = '0; req_code3 = '0; dec_result3 = '0;

    // Reset
    repeat (2) @(negedge clock);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dec_code", 32'(dec_code), 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("idle_dec_code", 32'(dec_code), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_req_ready", 32'(req_ready), 0);
      tick();
    end
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);

    // Single request from requester 2
    req_code[2*CW +: CW] = 7'b1100111;
    req_valid = 4'b0100;
    @(negedge clock); chk("single_ready", 32'(req_ready), 32'h4); tick();
    req_valid = '0;
    @(negedge clock);
    chk("single_dec_c1", 32'(dec_code), 32'h67);
    chk("single_busy_c1", 32'(busy), 1);
    chk("single_gid", 32'(grant_id), 2);
    chk("single_norsp_c1", 32'(rsp_valid), 0);
    tick();
    @(negedge clock);
    chk("single_dec_c2", 32'(dec_code), 32'h67);
    chk("single_busy_c2", 32'(busy), 1);
    tick();
    @(negedge clock);
    chk("single_rsp", 32'(rsp_valid), 32'h4);
    chk("single_result", 32'(rsp_result), 32'(dec_model(7'h67)));
    chk("single_busy_c3", 32'(busy), 1);
    tick();
    @(negedge clock);
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_rsp", 32'(rsp_valid), 0);
    chk("single_dec_hold", 32'(dec_code), 32'h67);
    tick();

    // Reset pulse so contention starts from the reset pointer
    reset_n = 1'b0;
    @(negedge clock); chk("pulse_dec_code", 32'(dec_code), 0); tick();
    reset_n = 1'b1;

    // Contention: everyone valid
    req_code = {7'h44, 7'h33, 7'h22, 7'h11};
    req_valid = 4'b1111;
    n = 0; gid_pend = 1'b0; gid_exp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (gid_pend) begin
        chk("cont_grant_id", 32'(grant_id), gid_exp);
        gid_pend = 1'b0;
      end
      if (req_ready != 0 && n < 5) begin
        ids[n] = oh2idx(req_ready);
        acc_cyc[n] = c;
        gid_exp = ids[n];
        gid_pend = 1'b1;
        n++;
      end
      tick();
    end
    req_valid = '0;
    chk("cont_count", n, 5);
    for (int i = 0; i < n; i++) begin
      chk("cont_order", ids[i], exp_order[i]);
      if (i > 0) chk("cont_gap", acc_cyc[i] - acc_cyc[i-1], SETTLE + 2);
    end
    repeat (6) begin @(negedge clock); tick(); end

    // Reset during HOLD
    req_code[1*CW +: CW] = 7'h2A;
    req_valid = 4'b0010;
    @(negedge clock); chk("hold_rst_ready", 32'(req_ready), 32'h2); tick();
    req_valid = '0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("hold_rst_rsp", 32'(rsp_valid), 0);
    chk("hold_rst_dec", 32'(dec_code), 0);
    chk("hold_rst_busy", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("post_rst_rsp", 32'(rsp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clock); chk("post_rst_winner", 32'(req_ready), 32'h1); tick();
    req_valid = '0;
    repeat (5) begin @(negedge clock); tick(); end

    // Sample point with SETTLE=3
    req_code3[CW-1:0] = 7'h15;
    req_valid3 = 4'b0001;
    dec_result3 = 8'h11;
    @(negedge clock); chk("s3_ready", 32'(req_ready3), 32'h1); tick();
    req_valid3 = '0; dec_result3 = 8'h22;
    @(negedge clock); chk("s3_busy", 32'(busy3), 1); tick();
    dec_result3 = 8'h33;
    @(negedge clock); chk("s3_norsp_c2", 32'(rsp_valid3), 0); tick();
    dec_result3 = 8'h44;
    @(negedge clock); chk("s3_norsp_c3", 32'(rsp_valid3), 0); tick();
    dec_result3 = 8'h55;
    @(negedge clock);
    chk("s3_rsp", 32'(rsp_valid3), 32'h1);
    chk("s3_result", 32'(rsp_result3), 32'h44);
    tick();
    @(negedge clock);
    chk("s3_result_hold", 32'(rsp_result3), 32'h44);
    chk("s3_rsp_done", 32'(rsp_valid3), 0);
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
